// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, ALU/branch encodings, writeback selects, FSM state and instruction class.
// The HALT state exists only when ILLEGAL_INSTR_EN is defined.
package rv32i_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // Branch compares share the ALU field; only the low 3 bits matter.
  localparam logic [3:0] BR_BEQ  = 4'b0000;
  localparam logic [3:0] BR_BNE  = 4'b0001;
  localparam logic [3:0] BR_BLT  = 4'b0100;
  localparam logic [3:0] BR_BGE  = 4'b0101;
  localparam logic [3:0] BR_BLTU = 4'b0110;
  localparam logic [3:0] BR_BGEU = 4'b0111;

  localparam logic [2:0] RFWD_ALU    = 3'd0;
  localparam logic [2:0] RFWD_LOAD   = 3'd1;
  localparam logic [2:0] RFWD_IMM    = 3'd2;
  localparam logic [2:0] RFWD_PC_IMM = 3'd3;
  localparam logic [2:0] RFWD_PC4    = 3'd4;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WB
`ifdef ILLEGAL_INSTR_EN
    , ST_HALT
`endif
  } state_t;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_L, CLS_S, CLS_B,
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_UNKNOWN
  } instr_class_t;

endpackage

// File: rtl/rv32i_multicycle_control_if.sv
// Data-bus request/response signals between the control FSM (master) and the bus side (slave).
interface rv32i_multicycle_control_if;
  logic [1:0] busAddrLsb;
  logic       busReady;
  logic       busWe;
  logic       busRe;
  logic [3:0] busStrb;

  modport master (input busAddrLsb, busReady, output busWe, busRe, busStrb);
  modport slave  (output busAddrLsb, busReady, input busWe, busRe, busStrb);
endinterface

// File: rtl/rv32i_main_decoder.sv
// Purely combinational main decoder: opcode/func3/func7[5] to datapath selects and instruction class.
module rv32i_main_decoder
  import rv32i_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   func3,
  input  logic         func7_b5,
  output instr_class_t instr_class,
  output logic [3:0]   aluControl,
  output logic         aluSrcMuxSel,
  output logic [2:0]   RFWDSrcMuxSel,
  output logic         branch,
  output logic         jal,
  output logic         jalr
);

  always_comb begin
    instr_class   = CLS_UNKNOWN;
    aluControl    = ALU_ADD;
    aluSrcMuxSel  = 1'b0;
    RFWDSrcMuxSel = RFWD_ALU;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    case (opcode)
      OP_R: begin
        instr_class = CLS_R;
        aluControl  = {func7_b5, func3};
      end
      OP_I: begin
        instr_class  = CLS_I;
        aluSrcMuxSel = 1'b1;
        // Only the shift-right pair uses bit 30; for the rest it is immediate data.
        aluControl   = (func3 == 3'b101) ? {func7_b5, 3'b101} : {1'b0, func3};
      end
      OP_L: begin
        instr_class   = CLS_L;
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = RFWD_LOAD;
      end
      OP_S: begin
        instr_class  = CLS_S;
        aluSrcMuxSel = 1'b1;
      end
      OP_B: begin
        instr_class = CLS_B;
        aluControl  = {1'b0, func3};
        branch      = 1'b1;
      end
      OP_LUI: begin
        instr_class   = CLS_LUI;
        RFWDSrcMuxSel = RFWD_IMM;
      end
      OP_AUIPC: begin
        instr_class   = CLS_AUIPC;
        RFWDSrcMuxSel = RFWD_PC_IMM;
      end
      OP_JAL: begin
        instr_class   = CLS_JAL;
        RFWDSrcMuxSel = RFWD_PC4;
        jal           = 1'b1;
      end
      OP_JALR: begin
        instr_class   = CLS_JALR;
        RFWDSrcMuxSel = RFWD_PC4;
        jal           = 1'b1;
        jalr          = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32i_multicycle_control.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXECUTE/MEM/WB) plus data-bus request side.
// Optional ILLEGAL_INSTR_EN: unknown opcodes halt the core and raise a sticky illegalInstr flag.
module rv32i_multicycle_control
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  rv32i_multicycle_control_if.master bus,
  output logic        PCEn,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        illegalInstr
);

  state_t       state;
  instr_class_t cls;
  logic [3:0]   dec_alu;
  logic         dec_src, dec_branch, dec_jal, dec_jalr;
  logic [2:0]   dec_rfwd;
  logic         decode_active, is_load, is_store;
  logic         bus_we, bus_re;
  logic [3:0]   bus_strb;
  logic         unused_instr_bits;

  assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  rv32i_main_decoder u_main_decoder (
    .opcode        (instrCode[6:0]),
    .func3         (instrCode[14:12]),
    .func7_b5      (instrCode[30]),
    .instr_class   (cls),
    .aluControl    (dec_alu),
    .aluSrcMuxSel  (dec_src),
    .RFWDSrcMuxSel (dec_rfwd),
    .branch        (dec_branch),
    .jal           (dec_jal),
    .jalr          (dec_jalr)
  );

  assign is_load  = (cls == CLS_L);
  assign is_store = (cls == CLS_S);

  always_comb begin
    decode_active = (state != ST_FETCH);
`ifdef ILLEGAL_INSTR_EN
    if (state == ST_HALT) decode_active = 1'b0;
`endif
  end

  assign aluControl    = decode_active ? dec_alu    : 4'd0;
  assign aluSrcMuxSel  = decode_active & dec_src;
  assign RFWDSrcMuxSel = decode_active ? dec_rfwd   : 3'd0;
  assign branch        = decode_active & dec_branch;
  assign jal           = decode_active & dec_jal;
  assign jalr          = decode_active & dec_jalr;

`ifdef ILLEGAL_INSTR_EN
  logic illegal_q;
  assign illegalInstr = illegal_q;
`else
  assign illegalInstr = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_FETCH;
`ifdef ILLEGAL_INSTR_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
`ifdef ILLEGAL_INSTR_EN
          if (cls == CLS_UNKNOWN) begin
            state     <= ST_HALT;
            illegal_q <= 1'b1;
          end else begin
            state <= ST_EXECUTE;
          end
`else
          state <= ST_EXECUTE;
`endif
        end
        ST_EXECUTE: state <= (is_load || is_store) ? ST_MEM : ST_FETCH;
        ST_MEM: begin
          if (bus.busReady) state <= is_load ? ST_WB : ST_FETCH;
        end
        ST_WB: state <= ST_FETCH;
`ifdef ILLEGAL_INSTR_EN
        ST_HALT: state <= ST_HALT;
`endif
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Strobes decode straight from the state register so an async reset clears them at once.
  always_comb begin
    PCEn      = 1'b0;
    regFileWe = 1'b0;
    bus_we    = 1'b0;
    bus_re    = 1'b0;
    case (state)
      ST_EXECUTE: begin
        if (!is_load && !is_store) begin
          PCEn      = 1'b1;
          regFileWe = (cls != CLS_B) && (cls != CLS_UNKNOWN);
        end
      end
      ST_MEM: begin
        bus_we = is_store;
        bus_re = is_load;
        PCEn   = is_store && bus.busReady;
      end
      ST_WB: begin
        PCEn      = 1'b1;
        regFileWe = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus_strb = 4'b0000;
    if (bus_we) begin
      case (instrCode[14:12])
        3'b000:  bus_strb = 4'b0001 << bus.busAddrLsb;
        3'b001:  bus_strb = 4'b0011 << {bus.busAddrLsb[1], 1'b0};
        3'b010:  bus_strb = 4'b1111;
        default: bus_strb = 4'b0000;
      endcase
    end
  end

  assign bus.busWe   = bus_we;
  assign bus.busRe   = bus_re;
  assign bus.busStrb = bus_strb;

endmodule

// File: tb/tb_rv32i_multicycle_control.sv
// Self-checking bench: per-cycle trace of every output against a phase-based reference model.
module tb_rv32i_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrCode;
  logic        PCEn, regFileWe, aluSrcMuxSel, branch, jal, jalr, illegalInstr;
  logic [3:0]  aluControl;
  logic [2:0]  RFWDSrcMuxSel;
  int          checks = 0;
  int          errors = 0;

  rv32i_multicycle_control_if bus_if ();

  rv32i_multicycle_control dut (
    .clk           (clk),
    .reset         (reset),
    .instrCode     (instrCode),
    .bus           (bus_if),
    .PCEn          (PCEn),
    .regFileWe     (regFileWe),
    .aluControl    (aluControl),
    .aluSrcMuxSel  (aluSrcMuxSel),
    .RFWDSrcMuxSel (RFWDSrcMuxSel),
    .branch        (branch),
    .jal           (jal),
    .jalr          (jalr),
    .illegalInstr  (illegalInstr)
  );

  always #5 clk = ~clk;

  localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4, PH_H = 5;

  function automatic bit known_op(input logic [6:0] op);
    return op inside {7'h33, 7'h03, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
  endfunction

  // {aluControl, aluSrcMuxSel, RFWDSrcMuxSel, branch, jal, jalr}
  function automatic logic [10:0] dec_model(input logic [31:0] ins);
    logic [2:0] f3;
    logic [3:0] alu;
    logic       src, br, j, jr;
    logic [2:0] wd;
    f3 = ins[14:12];
    alu = 4'd0; src = 1'b0; wd = 3'd0; br = 1'b0; j = 1'b0; jr = 1'b0;
    case (ins[6:0])
      7'h33: alu = {ins[30], f3};
      7'h13: begin src = 1'b1; alu = (f3 == 3'd5) ? {ins[30], 3'd5} : {1'b0, f3}; end
      7'h03: begin src = 1'b1; wd = 3'd1; end
      7'h23: src = 1'b1;
      7'h63: begin br = 1'b1; alu = {1'b0, f3}; end
      7'h37: wd = 3'd2;
      7'h17: wd = 3'd3;
      7'h6F: begin wd = 3'd4; j = 1'b1; end
      7'h67: begin wd = 3'd4; j = 1'b1; jr = 1'b1; end
      default: ;
    endcase
    return {alu, src, wd, br, j, jr};
  endfunction

  // {PCEn, regFileWe, decode(11), busWe, busRe, busStrb(4), illegalInstr}
  function automatic logic [19:0] exp_vec(input int ph, input logic [31:0] ins,
                                          input logic [1:0] lsb, input logic rdy);
    logic [10:0] d;
    logic        pc, we, bw, brd, ill, ld, st;
    logic [3:0]  strb;
    ld = (ins[6:0] == 7'h03);
    st = (ins[6:0] == 7'h23);
    d = (ph >= PH_D && ph <= PH_W) ? dec_model(ins) : 11'd0;
    pc = 1'b0; we = 1'b0; bw = 1'b0; brd = 1'b0; ill = 1'b0; strb = 4'd0;
    case (ph)
      PH_E: if (!ld && !st) begin
        pc = 1'b1;
        we = known_op(ins[6:0]) && (ins[6:0] != 7'h63);
      end
      PH_M: begin
        bw = st; brd = ld; pc = st && rdy;
        if (st) begin
          case (ins[14:12])
            3'd0: strb = 4'(1 << lsb);
            3'd1: strb = 4'(3 << (lsb & 2'b10));
            3'd2: strb = 4'hF;
            default: strb = 4'd0;
          endcase
        end
      end
      PH_W: begin pc = 1'b1; we = 1'b1; end
      PH_H: ill = 1'b1;
      default: ;
    endcase
    return {pc, we, d, bw, brd, strb, ill};
  endfunction

  function automatic logic [19:0] obs_vec();
    return {PCEn, regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel, branch, jal, jalr,
            bus_if.busWe, bus_if.busRe, bus_if.busStrb, illegalInstr};
  endfunction

  task automatic check_vec(input string tag, input logic [19:0] exp);
    logic [19:0] obs;
    obs = obs_vec();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input int ph, input logic [31:0] ins,
                      input logic [1:0] lsb, input logic rdy);
    @(negedge clk);
    instrCode         = ins;
    bus_if.busAddrLsb = lsb;
    bus_if.busReady   = rdy;
    #1;
    check_vec($sformatf("%s_ph%0d", tag, ph), exp_vec(ph, ins, lsb, rdy));
  endtask

  task automatic run_instr(input string tag, input logic [31:0] ins, input int waits,
                           input logic [1:0] lsb);
    logic ld, st;
    ld = (ins[6:0] == 7'h03);
    st = (ins[6:0] == 7'h23);
    step(tag, PH_F, ins, lsb, 1'($urandom_range(0, 1)));
    step(tag, PH_D, ins, lsb, 1'($urandom_range(0, 1)));
    step(tag, PH_E, ins, lsb, 1'($urandom_range(0, 1)));
    if (ld || st) begin
      for (int i = 0; i <= waits; i++) step(tag, PH_M, ins, lsb, (i == waits));
      if (ld) step(tag, PH_W, ins, lsb, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr(input int kind);
    logic [31:0] ins;
    logic [6:0]  op;
    ins = $urandom;
    case (kind)
      0: op = 7'h33;
      1: op = 7'h13;
      2: op = 7'h03;
      3: begin op = 7'h23; ins[14:12] = 3'($urandom_range(0, 2)); end
      4: op = 7'h63;
      5: op = 7'h37;
      6: op = 7'h17;
      7: op = 7'h6F;
      8: op = 7'h67;
      default: begin
        op = 7'($urandom);
        for (int t = 0; t < 50 && known_op(op); t++) op = 7'($urandom);
        if (known_op(op)) op = 7'h7F;
      end
    endcase
    ins[6:0] = op;
    return ins;
  endfunction

  initial begin
    int kind_max;
    logic [31:0] ins;
    reset             = 1'b1;
    instrCode         = 32'h0000A103;
    bus_if.busAddrLsb = 2'd0;
    bus_if.busReady   = 1'b1;
    @(posedge clk);
    #1 check_vec("reset_state", 20'd0);
    release_reset();

    run_instr("addi", 32'h00500093, 0, 2'd0);
    run_instr("lw_wait2", 32'h0000A103, 2, 2'd0);
    run_instr("sb_lsb2", 32'h00208123, 0, 2'd2);
    run_instr("beq", 32'h00000463, 0, 2'd0);
    run_instr("sh_lsb3", 32'h00209123, 1, 2'd3);
    run_instr("sw", 32'h0020A023, 0, 2'd1);
    run_instr("srai", 32'h4020D093, 0, 2'd0);
    run_instr("sub", 32'h402081B3, 0, 2'd0);
    run_instr("jalr", 32'h000080E7, 0, 2'd0);

    // Async reset in the middle of a load wait state.
    step("rst_mem", PH_F, 32'h0000A103, 2'd0, 1'b0);
    step("rst_mem", PH_D, 32'h0000A103, 2'd0, 1'b0);
    step("rst_mem", PH_E, 32'h0000A103, 2'd0, 1'b0);
    step("rst_mem", PH_M, 32'h0000A103, 2'd0, 1'b0);
    #1 reset = 1'b1;
    #1 check_vec("reset_async_mem", 20'd0);
    release_reset();
    run_instr("after_reset_lw", 32'h0000A103, 0, 2'd0);

`ifdef ILLEGAL_INSTR_EN
    kind_max = 8;
`else
    kind_max = 9;
`endif
    for (int n = 0; n < 150; n++) begin
      ins = rand_instr($urandom_range(0, kind_max));
      run_instr("rand", ins, $urandom_range(0, 3), 2'($urandom_range(0, 3)));
    end

`ifdef ILLEGAL_INSTR_EN
    step("illegal", PH_F, 32'hFFFFFFFF, 2'd0, 1'b1);
    step("illegal", PH_D, 32'hFFFFFFFF, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) step("illegal_halt", PH_H, 32'hFFFFFFFF, 2'd0, 1'b1);
    #1 reset = 1'b1;
    #1 check_vec("illegal_reset", 20'd0);
    release_reset();
    run_instr("after_halt_addi", 32'h00500093, 0, 2'd0);
`else
    run_instr("illegal_nop", 32'hFFFFFFFF, 0, 2'd0);
    run_instr("after_nop_addi", 32'h00500093, 0, 2'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_multicycle_control.md
# rv32i_multicycle_control

Multi-cycle control FSM for the RV32I core. It sits directly upstream of the datapath and decodes the fetched `instrCode`. It sequences FETCH/DECODE/EXECUTE/MEM/WB and drives every datapath select and strobe (`PCEn`, `regFileWe`, ALU and mux selects, branch/jump flags). It also owns the data-bus request side: write/read strobes, byte strobes, and the ready handshake.

## Interface
- No parameters.
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `instrCode`  in  32  current instruction from instruction memory; stable while PC is held
- `busAddrLsb`  in  2  `ExeReg_aluResult[1:0]` from the datapath
- `busReady`  in  1  data bus accepts/completes the current transfer this cycle
- `PCEn`  out  1  PC load enable
- `regFileWe`  out  1  register file write enable
- `aluControl`  out  4  ALU op; the low 3 bits select the branch compare
- `aluSrcMuxSel`  out  1  ALU operand B: 0 = rs2, 1 = imm
- `RFWDSrcMuxSel`  out  3  writeback source: 0 = ALU, 1 = load data, 2 = imm, 3 = PC+imm, 4 = PC+4
- `branch`, `jal`, `jalr`  out  1 each  PC-source controls
- `busWe`  out  1  store request
- `busRe`  out  1  load request
- `busStrb`  out  4  store byte strobes
- `illegalInstr`  out  1  sticky illegal-opcode flag

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT. Reset state is FETCH.
- FETCH → DECODE, unconditional.
- DECODE → EXECUTE. Under `ILLEGAL_INSTR_EN`, DECODE → HALT on an unknown opcode.
- EXECUTE:
  - R/I/LUI/AUIPC/JAL/JALR: `regFileWe=1`, `PCEn=1`, → FETCH.
  - B: `PCEn=1`, → FETCH.
  - L/S: → MEM.
- MEM:
  - Store: `busWe=1`.
  - Load: `busRe=1`.
  - Held until `busReady`.
  - On `busReady`, a store asserts `PCEn=1` → FETCH; a load → WB.
- WB (load only): `regFileWe=1`, `PCEn=1`, → FETCH.
- Decode outputs (`aluControl`, `aluSrcMuxSel`, `RFWDSrcMuxSel`, `branch`, `jal`, `jalr`) are combinational from `instrCode` in DECODE, EXECUTE, MEM and WB. They are forced to 0 in FETCH and HALT.
- `aluControl` encoding:
  - R-type: `{instr[30], func3}`.
  - I-type: `{instr[30], 101}` for SRLI/SRAI; `{0, func3}` for all other I-type.
  - B: `{0, func3}`.
  - L, S and all other opcodes: ADD = 0000.
- `aluSrcMuxSel=1` for I, L and S.
- RFWDSrcMuxSel values:
  - L = 1.
  - LUI = 2.
  - AUIPC = 3.
  - JAL/JALR = 4.
  - All other opcodes = 0.
- `branch=1` for B; `jal=1` for JAL and JALR; `jalr=1` for JALR.
- `busStrb`, driven only while `busWe=1`, otherwise 0:
  - SB: `4'b0001 << busAddrLsb`.
  - SH: `4'b0011 << (2*busAddrLsb[1])`.
  - SW: `4'b1111`.
- Opcodes: R 0110011, L 0000011, I 0010011, S 0100011, B 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.

## Timing
- Reset value of every output is 0. Reset is asynchronous, so reset mid-MEM drops `busWe`/`busRe` immediately.
- Latency:
  - ALU/branch/jump instructions: 3 cycles.
  - Stores: 4 + N cycles.
  - Loads: 5 + N cycles.
  - N = number of MEM cycles with `busReady=0`.
- `busReady` high in the first MEM cycle gives zero wait states. `busWe`/`busRe` and the address stay stable until the cycle `busReady` is sampled high.
- `busReady` outside MEM is ignored.
- `PCEn` is high for exactly one cycle per instruction, always in the instruction's last state.
- `regFileWe` is high for at most one cycle per instruction.
- `PCEn` and `regFileWe` are never asserted in FETCH or DECODE.

## Configuration
- `ILLEGAL_INSTR_EN` defined:
  - An unknown opcode in DECODE → HALT.
  - `illegalInstr` rises one cycle later and holds until reset.
  - All strobes stay 0 in HALT; the PC freezes.
- `ILLEGAL_INSTR_EN` undefined:
  - An unknown opcode executes as a NOP: EXECUTE with `PCEn=1` only, giving PC+4.
  - `illegalInstr` is tied to 0.
  - The HALT state is not built.

## Structure
- Shared package `rv32i_pkg` holds:
  - opcode constants;
  - `aluControl` encodings (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; BEQ–BGEU);
  - RFWDSrcMuxSel constants;
  - the state enum typedef.
- Sub-module `rv32i_main_decoder` is purely combinational: opcode/func3/func7 → decode outputs plus instruction class.
- The FSM, state gating and strobe logic stay in the top module.

## Test plan
- ADDI x1,x0,5 (0x00500093): `regFileWe` and `PCEn` are high only in cycle 3; `aluSrcMuxSel=1`; `aluControl=0000`.
- LW (0x0000A103) with `busReady` low for 2 MEM cycles: `busRe` is high for 3 cycles, then WB asserts `regFileWe=1` with `RFWDSrcMuxSel=1`; total 7 cycles.
- SB (0x00208123) with `busAddrLsb=2` and `busReady=1`: `busStrb=0100` and `busWe=1` for 1 cycle, with `PCEn` in the same cycle.
- BEQ (0x00000463): `branch=1`, `aluControl=0000`, `PCEn` in EXECUTE, `regFileWe` stays 0.
- Opcode 0xFFFFFFFF: with `ILLEGAL_INSTR_EN`, `illegalInstr=1` and no further `PCEn`; without it, a single `PCEn` and return to FETCH.
- Reset asserted during a load MEM wait: all outputs are 0 immediately, and FETCH follows reset release.
